grf_regfile: RTL and testbench
==============================

Name: grf_regfile

Overview:
- General register file directly upstream of the ALU in the single-cycle datapath.
- Supplies both ALU operands (RD1 drives ALU_DA, RD2 drives ALU_DB) from two asynchronous read ports.
- Takes the ALU result ALU_DC (or other writeback data) on one synchronous write port.
- Register 0 is hard-wired to zero.

Parameters:
- WIDTH, 32, data width of each register and of the ALU operands.
- ADDR_W, 5, address width; depth = 2**ADDR_W registers, index 0 hard-wired zero.

Ports:
- clk  input  1  system clock; all writes on rising edge.
- reset  input  1  asynchronous, active-high reset; clears all registers.
- RF_RA1  input  ADDR_W  read address, port 1.
- RF_RA2  input  ADDR_W  read address, port 2.
- RF_WA  input  ADDR_W  write address.
- RF_WD  input  WIDTH  write data (ALU_DC in the datapath).
- RF_WE  input  1  write enable, active-high.
- RF_RD1  output  WIDTH  read data, port 1 (feeds ALU_DA).
- RF_RD2  output  WIDTH  read data, port 2 (feeds ALU_DB).

Interface decisions:
- One clock, clk.
- reset is asynchronous and active-high.

Behaviour:
- Storage: registers 1..2**ADDR_W-1, each WIDTH bits. Register 0 has no storage.
- Reset:
  - reset high clears all registers to 0 immediately, without waiting for a clock edge.
  - RF_RD1 and RF_RD2 therefore read 0 while reset is asserted.
  - Reset wins over any write on the same edge; no write occurs while reset is high.
- Write:
  - On the rising edge of clk with reset low, RF_WE=1 and RF_WA!=0: reg[RF_WA] <= RF_WD.
  - RF_WE=0: no state change.
  - RF_WA=0: write silently discarded.
- Read:
  - Combinational, zero latency: RF_RDn = (RF_RAn==0) ? 0 : reg[RF_RAn].
  - Read addresses are independent. Both ports may address the same register.
- Write-then-read timing (default build):
  - A write becomes visible on RF_RDn in the cycle after the write edge.
  - When RF_RAn==RF_WA with RF_WE=1 in the same cycle, RF_RDn shows the old value until the edge.
- Reset deasserted mid-cycle: the first write takes effect on the next rising edge where reset is low.
- Width: no truncation or extension. RF_WD is stored bit-exact. X/Z inputs are not filtered.
- Reset value of all outputs: 0.

Optional Feature:
- Macro: GRF_BYPASS_EN.
- Defined:
  - Write-through forwarding is added to each read port.
  - If RF_WE=1, RF_WA!=0, reset=0 and RF_RAn==RF_WA, then RF_RDn = RF_WD combinationally in the same cycle.
  - Otherwise RF_RDn reads normally.
  - Reads of address 0 still return 0 even when RF_WA==0 and RF_WE=1.
- Undefined:
  - No forwarding; same-cycle read of the register being written returns the old contents.
  - The module has no bypass logic at all.

Test Plan:
- Reset: assert reset asynchronously between edges after writing reg5=32'h1234_5678 → RF_RD1 (RA1=5) drops to 0 before the next edge. All 31 registers read 0 after reset.
- Basic write/read:
  - Write reg3=32'hDEAD_BEEF, reg7=32'h0000_0001 on consecutive edges.
  - Then RA1=3, RA2=7 → RD1=32'hDEAD_BEEF, RD2=32'h0000_0001. Both ports at RA=3 → both read 32'hDEAD_BEEF.
- Zero register: WE=1, WA=0, WD=32'hFFFF_FFFF, clock → RD1 at RA1=0 reads 0. No other register changed.
- Write disabled: WE=0, WA=9, WD=32'hAAAA_5555, clock → reg9 still 0.
- Same-cycle read/write: reg4 holds 32'h11, then WE=1, WA=4, WD=32'h22, RA1=4.
  - Default build: RD1=32'h11 before the edge, 32'h22 after.
  - GRF_BYPASS_EN build: RD1=32'h22 before the edge.
- Reset vs write collision: reset=1 held across a rising edge with WE=1, WA=2, WD=32'h5 → reg2 reads 0 after reset releases.

Source files
------------

// File: rtl/grf_regfile_if.sv
// Register file access bundle: two read ports and one write port.
// The master side is the datapath, which drives addresses and write data; the slave side is the register file.
interface grf_regfile_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 5
);
    logic [ADDR_W-1:0] RF_RA1;
    logic [ADDR_W-1:0] RF_RA2;
    logic [ADDR_W-1:0] RF_WA;
    logic [WIDTH-1:0]  RF_WD;
    logic              RF_WE;
    logic [WIDTH-1:0]  RF_RD1;
    logic [WIDTH-1:0]  RF_RD2;

    modport master (
        output RF_RA1, RF_RA2, RF_WA, RF_WD, RF_WE,
        input  RF_RD1, RF_RD2
    );

    modport slave (
        input  RF_RA1, RF_RA2, RF_WA, RF_WD, RF_WE,
        output RF_RD1, RF_RD2
    );
endinterface

// File: rtl/grf_regfile.sv
// General register file feeding the ALU: two async read ports, one sync write port, r0 reads zero.
// Optional write-through forwarding on both read ports when GRF_BYPASS_EN is defined.
module grf_regfile #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic        clk,
    input  logic        reset,
    grf_regfile_if.slave rf
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    // Entry 0 has no storage; reads of address 0 are forced to zero below.
    logic [WIDTH-1:0] regs [1:DEPTH-1];

    logic wr_en_c;
    assign wr_en_c = rf.RF_WE && (rf.RF_WA != ADDR_W'(0));

    // Write port; reset clears the array asynchronously and wins over a same-edge write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < int'(DEPTH); i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en_c) begin
            regs[rf.RF_WA] <= rf.RF_WD;
        end
    end

`ifdef GRF_BYPASS_EN
    logic fwd1_c;
    logic fwd2_c;
    assign fwd1_c = wr_en_c && !reset && (rf.RF_RA1 == rf.RF_WA);
    assign fwd2_c = wr_en_c && !reset && (rf.RF_RA2 == rf.RF_WA);
`endif

    // Combinational read ports.
    always_comb begin
        rf.RF_RD1 = '0;
        rf.RF_RD2 = '0;
        if (rf.RF_RA1 != ADDR_W'(0)) begin
            rf.RF_RD1 = regs[rf.RF_RA1];
        end
        if (rf.RF_RA2 != ADDR_W'(0)) begin
            rf.RF_RD2 = regs[rf.RF_RA2];
        end
`ifdef GRF_BYPASS_EN
        if (fwd1_c) begin
            rf.RF_RD1 = rf.RF_WD;
        end
        if (fwd2_c) begin
            rf.RF_RD2 = rf.RF_WD;
        end
`endif
    end
endmodule

// File: tb/tb_grf_regfile.sv
// Directed self-checking bench for grf_regfile; covers both the default and GRF_BYPASS_EN builds.
module tb_grf_regfile;
    localparam int unsigned WIDTH  = 32;
    localparam int unsigned ADDR_W = 5;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    grf_regfile_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) rf_bus ();

    grf_regfile #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .rf    (rf_bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [WIDTH-1:0] got,
                             input logic [WIDTH-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One write on the next rising edge; returns 1 time unit after that edge with WE cleared.
    task automatic wr(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
        @(negedge clk);
        rf_bus.RF_WE = 1'b1;
        rf_bus.RF_WA = a;
        rf_bus.RF_WD = d;
        @(posedge clk);
        #1;
        rf_bus.RF_WE = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rf_bus.RF_RA1 = '0;
        rf_bus.RF_RA2 = '0;
        rf_bus.RF_WA  = '0;
        rf_bus.RF_WD  = '0;
        rf_bus.RF_WE  = 1'b0;
        rf_bus.RF_RA1 = 5'd3;
        rf_bus.RF_RA2 = 5'd31;
        #12;
        check_val("rst_rd1", rf_bus.RF_RD1, 32'h0);
        check_val("rst_rd2", rf_bus.RF_RD2, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Basic write and dual-port read
        wr(5'd3, 32'hDEAD_BEEF);
        wr(5'd7, 32'h0000_0001);
        rf_bus.RF_RA1 = 5'd3;
        rf_bus.RF_RA2 = 5'd7;
        #1;
        check_val("rd1_r3", rf_bus.RF_RD1, 32'hDEAD_BEEF);
        check_val("rd2_r7", rf_bus.RF_RD2, 32'h0000_0001);
        rf_bus.RF_RA2 = 5'd3;
        #1;
        check_val("both_r3_p1", rf_bus.RF_RD1, 32'hDEAD_BEEF);
        check_val("both_r3_p2", rf_bus.RF_RD2, 32'hDEAD_BEEF);

        // Writes to r0 are discarded and disturb nothing
        wr(5'd0, 32'hFFFF_FFFF);
        rf_bus.RF_RA1 = 5'd0;
        rf_bus.RF_RA2 = 5'd7;
        #1;
        check_val("r0_zero", rf_bus.RF_RD1, 32'h0);
        check_val("r0_wr_r7", rf_bus.RF_RD2, 32'h0000_0001);
        rf_bus.RF_RA2 = 5'd3;
        #1;
        check_val("r0_wr_r3", rf_bus.RF_RD2, 32'hDEAD_BEEF);

        // WE low: no state change
        @(negedge clk);
        rf_bus.RF_WE = 1'b0;
        rf_bus.RF_WA = 5'd9;
        rf_bus.RF_WD = 32'hAAAA_5555;
        @(posedge clk);
        #1;
        rf_bus.RF_RA1 = 5'd9;
        #1;
        check_val("we0_r9", rf_bus.RF_RD1, 32'h0);

        // Top address, bit-exact data
        wr(5'd31, 32'h8000_0001);
        rf_bus.RF_RA2 = 5'd31;
        #1;
        check_val("r31", rf_bus.RF_RD2, 32'h8000_0001);

        // Same-cycle read of the register being written
        wr(5'd4, 32'h11);
        @(negedge clk);
        rf_bus.RF_WE  = 1'b1;
        rf_bus.RF_WA  = 5'd4;
        rf_bus.RF_WD  = 32'h22;
        rf_bus.RF_RA1 = 5'd4;
        rf_bus.RF_RA2 = 5'd3;
        #1;
`ifdef GRF_BYPASS_EN
        check_val("same_cyc_pre", rf_bus.RF_RD1, 32'h22);
`else
        check_val("same_cyc_pre", rf_bus.RF_RD1, 32'h11);
`endif
        check_val("same_cyc_other", rf_bus.RF_RD2, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        check_val("same_cyc_post", rf_bus.RF_RD1, 32'h22);
        rf_bus.RF_WE = 1'b0;

        // r0 stays zero even when writing to address 0 and reading it in the same cycle
        @(negedge clk);
        rf_bus.RF_WE  = 1'b1;
        rf_bus.RF_WA  = 5'd0;
        rf_bus.RF_WD  = 32'hFFFF_FFFF;
        rf_bus.RF_RA1 = 5'd0;
        #1;
        check_val("r0_fwd", rf_bus.RF_RD1, 32'h0);
        @(posedge clk);
        #1;
        rf_bus.RF_WE = 1'b0;

        // Asynchronous reset between edges
        wr(5'd5, 32'h1234_5678);
        rf_bus.RF_RA1 = 5'd5;
        #1;
        check_val("r5_before_rst", rf_bus.RF_RD1, 32'h1234_5678);
        #1;
        reset = 1'b1;
        #1;
        check_val("async_rst_r5", rf_bus.RF_RD1, 32'h0);
        for (int a = 1; a < 32; a++) begin
            rf_bus.RF_RA1 = 5'(a);
            #1;
            check_val($sformatf("rst_r%0d", a), rf_bus.RF_RD1, 32'h0);
        end

        // Reset held across an edge with a write pending
        @(negedge clk);
        rf_bus.RF_WE = 1'b1;
        rf_bus.RF_WA = 5'd2;
        rf_bus.RF_WD = 32'h5;
        @(posedge clk);
        #1;
        rf_bus.RF_WE = 1'b0;
        reset = 1'b0;
        rf_bus.RF_RA1 = 5'd2;
        #1;
        check_val("rst_vs_wr_r2", rf_bus.RF_RD1, 32'h0);

        // Reset released mid-cycle: write lands on the following edge
        @(negedge clk);
        reset = 1'b1;
        rf_bus.RF_WE = 1'b1;
        rf_bus.RF_WA = 5'd6;
        rf_bus.RF_WD = 32'h66;
        rf_bus.RF_RA2 = 5'd6;
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        rf_bus.RF_WE = 1'b0;
        check_val("rst_release_r6", rf_bus.RF_RD2, 32'h66);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
